// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII PHY-side frame source.
//   - speed codes as driven on cfg_speed (11 is folded onto 1G by decode_speed)
//   - Ethernet preamble / SFD byte values
//   - CRC-32 constants and a one-byte reflected CRC update helper
//   - frame source state encoding
package rgmii_pkg;

    typedef enum logic [1:0] {
        SPEED_10M  = 2'b00,
        SPEED_100M = 2'b01,
        SPEED_1G   = 2'b10
    } speed_e;

    localparam logic [7:0] ETH_PRE = 8'h55;
    localparam logic [7:0] ETH_SFD = 8'hD5;

    localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
    // Bit-reversed CRC32_POLY, used because the CRC is computed LSB first.
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    // Register value left after running data plus its own FCS through the CRC.
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA     = 3'd2,
        ST_FCS      = 3'd3,
        ST_IFG      = 3'd4,
        ST_DROP     = 3'd5
    } state_e;

    // Reflected CRC-32 update over one byte, data bit 0 first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Map the raw speed strap to a speed code; the reserved 11 runs as 1G.
    function automatic speed_e decode_speed(input logic [1:0] code);
        case (code)
            2'b00:   return SPEED_10M;
            2'b01:   return SPEED_100M;
            default: return SPEED_1G;
        endcase
    endfunction

endpackage

// File: rtl/rgmii_phy_source_if.sv
// AXI-stream byte channel feeding the RGMII frame source.
//   tdata/tvalid/tlast/tuser : driven by the producer (master)
//   tready                   : driven by the frame source (slave)
interface rgmii_phy_source_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/eth_crc32_byte.sv
// Combinational Ethernet CRC-32 step over one byte (reflected, no final xor).
//   crc_in  : current CRC register
//   data    : byte to absorb
//   crc_out : CRC register after the byte
module eth_crc32_byte
    import rgmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);
    assign crc_out = crc32_byte(crc_in, data);
endmodule

// File: rtl/rgmii_phy_source.sv
// PHY-side RGMII receive source: frames AXI-stream bytes as preamble/SFD,
// payload, FCS and inter-frame gap, and drives RGMII rx as SDR rise/fall pairs.
//   clk, rst_n            : 125 MHz clock, async active-low reset
//   s_axis                : payload byte stream (slave side)
//   rgmii_rxd_rise/fall   : rxd nibble for the rising / falling PHY edge
//   rgmii_rx_ctl_rise/fall: rx_dv / rx_dv^rx_er
//   rgmii_rx_clk_en       : one-cycle strobe when a new rise/fall pair is shown
//   cfg_*                 : speed, gap, link and duplex configuration
//   busy, frame_count     : status
module rgmii_phy_source
    import rgmii_pkg::*;
#(
    parameter int IFG_MIN  = 1,
    parameter int DIV_100M = 5,
    parameter int DIV_10M  = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    rgmii_phy_source_if.slave s_axis,
    output logic [3:0]        rgmii_rxd_rise,
    output logic [3:0]        rgmii_rxd_fall,
    output logic              rgmii_rx_ctl_rise,
    output logic              rgmii_rx_ctl_fall,
    output logic              rgmii_rx_clk_en,
    input  logic [1:0]        cfg_speed,
    input  logic [7:0]        cfg_ifg,
    input  logic              cfg_link_up,
    input  logic              cfg_full_duplex,
    output logic              busy,
    output logic [15:0]       frame_count
);
    localparam logic [7:0] IFG_FLOOR = 8'(IFG_MIN);

    state_e      state_r, state_next_s;
    speed_e      speed_r, speed_s;
    logic [1:0]  speed_bits_s;
    logic [7:0]  ifg_r, gap_last_s;
    logic [15:0] presc_r, div_s;
    logic        en_s, mii_s, need_new_s, byte_done_s, cur_last_s;
    logic [7:0]  idx_r, hold_r;
    logic        hi_r, last_r, user_r;
    logic [31:0] crc_r, crc_next_s, fcs_s;
    logic        tready_s, accept_s, unit_dv_s, unit_er_s;
    logic [7:0]  unit_byte_s;
    logic [3:0]  status_s, rise_s, fall_s;
    logic [3:0]  rise_r, fall_r;
    logic        ctl_rise_r, ctl_fall_r, clk_en_r, busy_r;
    logic [15:0] frame_count_r;

    // Speed only follows cfg_speed while idle; a running frame keeps its speed.
    assign speed_s      = (state_r == ST_IDLE) ? decode_speed(cfg_speed) : speed_r;
    assign speed_bits_s = speed_s;
    assign mii_s        = (speed_s != SPEED_1G);
    assign en_s         = (presc_r == 16'd0);
    // In MII a byte is fetched at the low-nibble en and held for the high nibble.
    assign need_new_s   = !mii_s || !hi_r;
    assign byte_done_s  = en_s && (!mii_s || hi_r);
    assign cur_last_s   = need_new_s ? s_axis.tlast : last_r;
    assign gap_last_s   = ((ifg_r > IFG_FLOOR) ? ifg_r : IFG_FLOOR) - 8'd1;
    assign status_s     = {cfg_full_duplex, speed_bits_s, cfg_link_up};
    assign fcs_s        = ~crc_r;

    eth_crc32_byte u_crc (
        .crc_in  (crc_r),
        .data    (s_axis.tdata),
        .crc_out (crc_next_s)
    );

    // Prescaler reload value for the active speed.
    always_comb begin
        case (speed_s)
            SPEED_10M:  div_s = 16'(DIV_10M);
            SPEED_100M: div_s = 16'(DIV_100M);
            default:    div_s = 16'd1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en_s && s_axis.tvalid && cfg_link_up) state_next_s = ST_PREAMBLE;
                else                                      state_next_s = ST_IDLE;
            end
            ST_PREAMBLE: begin
                if (byte_done_s && (idx_r == 8'd7)) state_next_s = ST_DATA;
                else                                state_next_s = ST_PREAMBLE;
            end
            ST_DATA: begin
                if (en_s && need_new_s && !s_axis.tvalid) state_next_s = ST_DROP;
                else if (byte_done_s && cur_last_s)       state_next_s = ST_FCS;
                else                                      state_next_s = ST_DATA;
            end
            ST_FCS: begin
                if (byte_done_s && (idx_r == 8'd3)) state_next_s = ST_IFG;
                else                                state_next_s = ST_FCS;
            end
            ST_IFG: begin
                if (byte_done_s && (idx_r == gap_last_s)) state_next_s = ST_IDLE;
                else                                      state_next_s = ST_IFG;
            end
            ST_DROP: begin
                if (s_axis.tvalid && s_axis.tlast) state_next_s = ST_IFG;
                else                               state_next_s = ST_DROP;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: byte for this unit, rx_dv/rx_er and the stream handshake.
    always_comb begin
        tready_s    = 1'b0;
        accept_s    = 1'b0;
        unit_dv_s   = 1'b0;
        unit_er_s   = 1'b0;
        unit_byte_s = {status_s, status_s};
        case (state_r)
            ST_IDLE: unit_byte_s = {status_s, status_s};
            ST_PREAMBLE: begin
                unit_dv_s   = 1'b1;
                unit_byte_s = (idx_r == 8'd7) ? ETH_SFD : ETH_PRE;
            end
            ST_DATA: begin
                unit_dv_s = 1'b1;
                if (need_new_s) begin
                    tready_s = en_s;
                    accept_s = en_s && s_axis.tvalid;
                    if (s_axis.tvalid) begin
                        unit_byte_s = s_axis.tdata;
                        unit_er_s   = s_axis.tlast && s_axis.tuser;
                    end else begin
                        // Underflow: mark the unit as an error with zero data.
                        unit_byte_s = 8'h00;
                        unit_er_s   = 1'b1;
                    end
                end else begin
                    unit_byte_s = hold_r;
                    unit_er_s   = user_r;
                end
            end
            ST_FCS: begin
                unit_dv_s   = 1'b1;
                unit_byte_s = fcs_s[{idx_r[1:0], 3'b000} +: 8];
            end
            ST_IFG:  unit_byte_s = {status_s, status_s};
            ST_DROP: tready_s = 1'b1;
            default: unit_byte_s = {status_s, status_s};
        endcase
    end

    // Split the unit byte into the rise/fall nibble pair for the active speed.
    always_comb begin
        if (!mii_s) begin
            rise_s = unit_byte_s[3:0];
            fall_s = unit_byte_s[7:4];
        end else if (hi_r) begin
            rise_s = unit_byte_s[7:4];
            fall_s = unit_byte_s[7:4];
        end else begin
            rise_s = unit_byte_s[3:0];
            fall_s = unit_byte_s[3:0];
        end
    end

    assign s_axis.tready = tready_s;

    // Prescaler and idle-time latch of speed and gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= 16'd0;
            speed_r <= SPEED_1G;
            ifg_r   <= 8'd0;
        end else begin
            if (state_r == ST_IDLE) begin
                speed_r <= decode_speed(cfg_speed);
                ifg_r   <= cfg_ifg;
            end
            if ((state_r == ST_IDLE) && (state_next_s == ST_IDLE)) begin
                presc_r <= 16'd0;
            end else if (en_s) begin
                presc_r <= div_s - 16'd1;
            end else begin
                presc_r <= presc_r - 16'd1;
            end
        end
    end

    // Byte index within the current state and MII nibble phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= 8'd0;
            hi_r  <= 1'b0;
        end else if (state_next_s != state_r) begin
            idx_r <= 8'd0;
            hi_r  <= 1'b0;
        end else if (en_s) begin
            if (mii_s) hi_r <= !hi_r;
            if (byte_done_s) idx_r <= idx_r + 8'd1;
        end
    end

    // CRC accumulation and holding of the accepted byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_r  <= CRC32_INIT;
            hold_r <= 8'd0;
            last_r <= 1'b0;
            user_r <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            crc_r <= CRC32_INIT;
        end else if (accept_s) begin
            crc_r  <= crc_next_s;
            hold_r <= s_axis.tdata;
            last_r <= s_axis.tlast;
            user_r <= s_axis.tlast && s_axis.tuser;
        end
    end

    // Registered RGMII pins and status; pins change only on en, strobe follows en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_r        <= 4'd0;
            fall_r        <= 4'd0;
            ctl_rise_r    <= 1'b0;
            ctl_fall_r    <= 1'b0;
            clk_en_r      <= 1'b0;
            busy_r        <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            clk_en_r <= en_s;
            busy_r   <= (state_next_s != ST_IDLE);
            if (en_s) begin
                rise_r     <= rise_s;
                fall_r     <= fall_s;
                ctl_rise_r <= unit_dv_s;
                ctl_fall_r <= unit_dv_s ^ unit_er_s;
            end
            if ((state_r == ST_IFG) && (state_next_s == ST_IDLE)) begin
                frame_count_r <= frame_count_r + 16'd1;
            end
        end
    end

    assign rgmii_rxd_rise    = rise_r;
    assign rgmii_rxd_fall    = fall_r;
    assign rgmii_rx_ctl_rise = ctl_rise_r;
    assign rgmii_rx_ctl_fall = ctl_fall_r;
    assign rgmii_rx_clk_en   = clk_en_r;
    assign busy              = busy_r;
    assign frame_count       = frame_count_r;

endmodule

// File: tb/tb_rgmii_phy_source.sv
// Self-checking bench for rgmii_phy_source: directed and random frames at all
// speeds, decoded from the captured RGMII units and compared with a reference
// built from Ethernet framing rules.
module tb_rgmii_phy_source;
    localparam int PERIOD = 8;

    typedef logic [7:0] byteq_t[$];
    typedef struct {
        logic [3:0] rise;
        logic [3:0] fall;
        logic       cr;
        logic       cf;
        logic       busy;
        longint     t;
    } unit_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  rxd_rise, rxd_fall;
    logic        ctl_rise, ctl_fall, clk_en, busy;
    logic [1:0]  cfg_speed = 2'b10;
    logic [7:0]  cfg_ifg = 8'd12;
    logic        cfg_link_up = 1'b1;
    logic        cfg_full_duplex = 1'b1;
    logic [15:0] frame_count;

    int checks = 0;
    int failures = 0;
    int exp_fc = 0;
    unit_t units[$];

    always #4 clk = ~clk;

    rgmii_phy_source_if axis ();

    rgmii_phy_source #(.IFG_MIN(1), .DIV_100M(5), .DIV_10M(50)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axis            (axis),
        .rgmii_rxd_rise    (rxd_rise),
        .rgmii_rxd_fall    (rxd_fall),
        .rgmii_rx_ctl_rise (ctl_rise),
        .rgmii_rx_ctl_fall (ctl_fall),
        .rgmii_rx_clk_en   (clk_en),
        .cfg_speed         (cfg_speed),
        .cfg_ifg           (cfg_ifg),
        .cfg_link_up       (cfg_link_up),
        .cfg_full_duplex   (cfg_full_duplex),
        .busy              (busy),
        .frame_count       (frame_count)
    );

    // Capture every strobed rise/fall pair on the falling edge.
    always @(negedge clk) begin
        unit_t u;
        if (clk_en === 1'b1) begin
            u.rise = rxd_rise;
            u.fall = rxd_fall;
            u.cr   = ctl_rise;
            u.cf   = ctl_fall;
            u.busy = busy;
            u.t    = longint'($time);
            units.push_back(u);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ethernet CRC-32 register (no final inversion) over a byte stream.
    function automatic logic [31:0] crc_raw(input byteq_t q);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    function automatic byteq_t rand_payload(input int n);
        byteq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    function automatic int speed_div(input logic [1:0] code);
        if (code == 2'b00) return 50;
        if (code == 2'b01) return 5;
        return 1;
    endfunction

    // Offer one byte (called at a falling edge); returns at the falling edge after acceptance.
    task automatic push_byte(input logic [7:0] d, input bit last, input bit user, output bit ok);
        axis.tdata  = d;
        axis.tvalid = 1'b1;
        axis.tlast  = last;
        axis.tuser  = user;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            #3;
            if (axis.tready === 1'b1) ok = 1'b1;
            @(negedge clk);
            if (ok) break;
        end
    endtask

    task automatic send_frame(input byteq_t pl, input bit user_last, input int switch_at,
                              input logic [1:0] new_speed);
        bit ok;
        foreach (pl[i]) begin
            if (i == switch_at) cfg_speed = new_speed;
            push_byte(pl[i], i == pl.size() - 1, user_last && (i == pl.size() - 1), ok);
            chk("byte_accept", ok, 1);
            if (!ok) break;
        end
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
        axis.tuser  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (busy !== 1'b0 && c < 20000) begin
            @(negedge clk);
            c++;
        end
        chk(tag, busy, 0);
        repeat (2) @(negedge clk);
    endtask

    // Decode the captured frame and compare with the expected Ethernet frame.
    task automatic analyze(input string tag, input int mii, input int div, input byteq_t pl,
                           input int gap, input bit user_last);
        int s, n, upb, bad, g, nb, ecf;
        byteq_t bytes, fb;
        logic [31:0] fcs_exp;
        upb = mii ? 2 : 1;
        nb  = pl.size();
        s = -1;
        for (int i = 0; i < units.size(); i++) if (units[i].cr) begin s = i; break; end
        n = 0;
        if (s >= 0) while (s + n < units.size() && units[s + n].cr) n++;
        chk({tag, "_units"}, n, (12 + nb) * upb);
        if (n != (12 + nb) * upb) return;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            ecf = (user_last && (i / upb == 8 + nb - 1)) ? 0 : 1;
            if (units[s + i].cf !== 1'(ecf)) bad++;
            if (mii && units[s + i].rise !== units[s + i].fall) bad++;
            if (i > 0 && units[s + i].t - units[s + i - 1].t != longint'(div * PERIOD)) bad++;
        end
        chk({tag, "_ctl_period"}, bad, 0);
        for (int b = 0; b < n / upb; b++) begin
            if (mii) bytes.push_back({units[s + 2 * b + 1].rise, units[s + 2 * b].rise});
            else     bytes.push_back({units[s + b].fall, units[s + b].rise});
        end
        bad = 0;
        for (int b = 0; b < 7; b++) if (bytes[b] !== 8'h55) bad++;
        chk({tag, "_preamble"}, bad, 0);
        chk({tag, "_sfd"}, bytes[7], 8'hD5);
        bad = 0;
        for (int b = 0; b < nb; b++) if (bytes[8 + b] !== pl[b]) bad++;
        chk({tag, "_payload"}, bad, 0);
        fcs_exp = ~crc_raw(pl);
        bad = 0;
        for (int j = 0; j < 4; j++) if (bytes[8 + nb + j] !== fcs_exp[8 * j +: 8]) bad++;
        chk({tag, "_fcs"}, bad, 0);
        for (int b = 8; b < 12 + nb; b++) fb.push_back(bytes[b]);
        chk({tag, "_residue"}, crc_raw(fb), 32'hDEBB20E3);
        g = 0;
        for (int i = s + n; i < units.size(); i++) begin
            if (!units[i].cr && !units[i].cf) g++;
            if (!units[i].busy) break;
        end
        chk({tag, "_gap"}, g, gap * upb);
    endtask

    initial begin
        byteq_t pl;
        bit ok;
        int k, len, ifg;
        logic [1:0] spd;
        axis.tdata = 8'h00; axis.tvalid = 1'b0; axis.tlast = 1'b0; axis.tuser = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #5;
        chk("rst_rxd", {rxd_rise, rxd_fall}, 0);
        chk("rst_ctl_en_busy", {ctl_rise, ctl_fall, clk_en, busy}, 0);
        chk("rst_frame_count", frame_count, 0);
        @(negedge clk) rst_n = 1'b1;

        // In-band status while idle
        repeat (3) @(negedge clk);
        chk("inband_up", {rxd_rise, rxd_fall, ctl_rise, ctl_fall}, {4'b1101, 4'b1101, 2'b00});
        cfg_link_up = 1'b0;
        repeat (3) @(negedge clk);
        chk("inband_down", {rxd_rise, rxd_fall}, {4'b1100, 4'b1100});
        axis.tvalid = 1'b1;
        repeat (20) @(negedge clk);
        chk("link_down_gate", {busy, axis.tready}, 0);
        axis.tvalid = 1'b0;
        cfg_link_up = 1'b1;
        repeat (2) @(negedge clk);

        // 1G ramp frame
        pl.delete();
        for (int i = 0; i < 60; i++) pl.push_back(8'(i));
        units.delete();
        send_frame(pl, 1'b0, -1, 2'b10);
        wait_idle("idle_1g");
        exp_fc++;
        analyze("f1g", 0, 1, pl, 12, 1'b0);
        chk("fc_1g", frame_count, exp_fc);

        // 100M ramp frame
        cfg_speed = 2'b01;
        units.delete();
        send_frame(pl, 1'b0, -1, 2'b01);
        wait_idle("idle_100m");
        exp_fc++;
        analyze("f100m", 1, 5, pl, 12, 1'b0);
        chk("fc_100m", frame_count, exp_fc);

        // Underflow at 1G after 10 bytes
        cfg_speed = 2'b10;
        pl = rand_payload(16);
        k = 10;
        units.delete();
        for (int i = 0; i < k; i++) begin
            push_byte(pl[i], 1'b0, 1'b0, ok);
            chk("uf_accept", ok, 1);
        end
        axis.tvalid = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = k; i < 16; i++) begin
            push_byte(pl[i], i == 15, 1'b0, ok);
            chk("uf_drain", ok, 1);
        end
        axis.tvalid = 1'b0; axis.tlast = 1'b0;
        wait_idle("idle_uf");
        exp_fc++;
        begin
            int s, n, bad;
            s = -1;
            for (int i = 0; i < units.size(); i++) if (units[i].cr) begin s = i; break; end
            n = 0;
            if (s >= 0) while (s + n < units.size() && units[s + n].cr) n++;
            chk("uf_len", n, 8 + k + 1);
            if (n == 8 + k + 1) begin
                chk("uf_err_unit", {units[s + 8 + k].cf, units[s + 8 + k].rise, units[s + 8 + k].fall}, 0);
                bad = 0;
                for (int b = 0; b < k; b++)
                    if ({units[s + 8 + b].fall, units[s + 8 + b].rise} !== pl[b]) bad++;
                chk("uf_data", bad, 0);
            end
        end
        chk("fc_uf", frame_count, exp_fc);

        // tuser on the last byte at 100M
        cfg_speed = 2'b01;
        pl = rand_payload(int'($urandom_range(1, 20)));
        units.delete();
        send_frame(pl, 1'b1, -1, 2'b01);
        wait_idle("idle_user");
        exp_fc++;
        analyze("fuser", 1, 5, pl, 12, 1'b1);

        // Speed change 1G -> 10M in the middle of a frame
        cfg_speed = 2'b10;
        cfg_ifg = 8'd3;
        pl = rand_payload(30);
        units.delete();
        send_frame(pl, 1'b0, 10, 2'b00);
        wait_idle("idle_sw1");
        exp_fc++;
        analyze("fsw_1g", 0, 1, pl, 3, 1'b0);
        pl = rand_payload(8);
        units.delete();
        send_frame(pl, 1'b0, -1, 2'b00);
        wait_idle("idle_sw2");
        exp_fc++;
        analyze("fsw_10m", 1, 50, pl, 3, 1'b0);
        chk("fc_sw", frame_count, exp_fc);

        // Random frames at random speed and gap
        for (int r = 0; r < 3; r++) begin
            spd = 2'($urandom_range(0, 3));
            ifg = int'($urandom_range(0, 6));
            len = int'($urandom_range(1, 24));
            cfg_speed = spd;
            cfg_ifg = 8'(ifg);
            pl = rand_payload(len);
            units.delete();
            send_frame(pl, 1'b0, -1, spd);
            wait_idle("idle_rand");
            exp_fc++;
            analyze("frand", (spd < 2'b10) ? 1 : 0, speed_div(spd), pl, (ifg < 1) ? 1 : ifg, 1'b0);
        end
        chk("fc_rand", frame_count, exp_fc);

        // Asynchronous reset in the middle of DATA, then a clean frame
        cfg_speed = 2'b10;
        cfg_ifg = 8'd12;
        pl = rand_payload(20);
        for (int i = 0; i < 5; i++) push_byte(pl[i], 1'b0, 1'b0, ok);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_rxd", {rxd_rise, rxd_fall}, 0);
        chk("arst_ctl_en_busy", {ctl_rise, ctl_fall, clk_en, busy}, 0);
        chk("arst_frame_count", frame_count, 0);
        axis.tvalid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        exp_fc = 0;
        repeat (2) @(negedge clk);
        pl = rand_payload(int'($urandom_range(5, 30)));
        units.delete();
        send_frame(pl, 1'b0, -1, 2'b10);
        wait_idle("idle_arst");
        exp_fc++;
        analyze("farst", 0, 1, pl, 12, 1'b0);
        chk("fc_arst", frame_count, exp_fc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
